// File: rtl/regfile_scoreboard_if.sv
// Decode-stage register file port bundle: writeback, two read ports, issue/flush and
// scoreboard status.
interface regfile_scoreboard_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 5
);
  logic                 ctrl_writeEnable;
  logic [ADDR_BITS-1:0] ctrl_writeReg;
  logic [WIDTH-1:0]     data_writeReg;
  logic [ADDR_BITS-1:0] ctrl_readRegA;
  logic [ADDR_BITS-1:0] ctrl_readRegB;
  logic [WIDTH-1:0]     data_readRegA;
  logic [WIDTH-1:0]     data_readRegB;
  logic                 ctrl_issueEnable;
  logic [ADDR_BITS-1:0] ctrl_issueReg;
  logic                 ctrl_flush;
  logic                 busy_A;
  logic                 busy_B;
  logic [ADDR_BITS:0]   pending_count;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
           ctrl_issueEnable, ctrl_issueReg, ctrl_flush,
    input  data_readRegA, data_readRegB, busy_A, busy_B, pending_count
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
           ctrl_issueEnable, ctrl_issueReg, ctrl_flush,
    output data_readRegA, data_readRegB, busy_A, busy_B, pending_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with write-through bypass, optional hardwired zero register and a
// per-register pending-write scoreboard with a running popcount.
module regfile_scoreboard #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 5,
  parameter bit          ZERO_REG  = 1'b1
) (
  input  logic               clock,
  input  logic               ctrl_reset,
  regfile_scoreboard_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CNT_W = ADDR_BITS + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic wr_valid, issue_valid, bit_set, bit_clr;
  logic bypass_a, bypass_b;

  assign wr_valid    = bus.ctrl_writeEnable && !(ZERO_REG && bus.ctrl_writeReg == '0);
  assign issue_valid = bus.ctrl_issueEnable && !(ZERO_REG && bus.ctrl_issueReg == '0);
  assign bypass_a    = bus.ctrl_writeEnable && (bus.ctrl_writeReg == bus.ctrl_readRegA);
  assign bypass_b    = bus.ctrl_writeEnable && (bus.ctrl_writeReg == bus.ctrl_readRegB);

  // At most one bit can rise (issue) and one fall (writeback) per non-flush cycle.
  assign bit_set = issue_valid && !pending_q[bus.ctrl_issueReg];
  assign bit_clr = wr_valid && pending_q[bus.ctrl_writeReg] &&
                   !(issue_valid && bus.ctrl_issueReg == bus.ctrl_writeReg);

  always_comb begin
    pending_d = bus.ctrl_flush ? '0 : pending_q;
    if (!bus.ctrl_flush && wr_valid) pending_d[bus.ctrl_writeReg] = 1'b0;
    // A same-cycle issue is the newer producer and overrides the writeback clear.
    if (issue_valid) pending_d[bus.ctrl_issueReg] = 1'b1;
    if (ZERO_REG) pending_d[0] = 1'b0;

    if (bus.ctrl_flush) begin
      count_d = issue_valid ? CNT_W'(1) : '0;
    end else begin
      count_d = count_q + CNT_W'(bit_set) - CNT_W'(bit_clr);
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      if (wr_valid) mem_q[bus.ctrl_writeReg] <= bus.data_writeReg;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    if (ZERO_REG && bus.ctrl_readRegA == '0) begin
      bus.data_readRegA = '0;
    end else if (bypass_a) begin
      bus.data_readRegA = bus.data_writeReg;
    end else begin
      bus.data_readRegA = mem_q[bus.ctrl_readRegA];
    end

    if (ZERO_REG && bus.ctrl_readRegB == '0) begin
      bus.data_readRegB = '0;
    end else if (bypass_b) begin
      bus.data_readRegB = bus.data_writeReg;
    end else begin
      bus.data_readRegB = mem_q[bus.ctrl_readRegB];
    end
  end

  // A register being written back this cycle is served by the bypass, so it is not busy.
  assign bus.busy_A        = pending_q[bus.ctrl_readRegA] && !bypass_a;
  assign bus.busy_B        = pending_q[bus.ctrl_readRegB] && !bypass_b;
  assign bus.pending_count = count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed table-driven bench for regfile_scoreboard: 32x32 default instance plus an
// 8x16 instance for the narrow-configuration checks.
module tb_regfile_scoreboard;

  logic clock = 1'b0;
  logic ctrl_reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  regfile_scoreboard_if #(.WIDTH(32), .ADDR_BITS(5)) bus ();
  regfile_scoreboard_if #(.WIDTH(16), .ADDR_BITS(3)) bus2 ();

  regfile_scoreboard #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1'b1)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  regfile_scoreboard #(.WIDTH(16), .ADDR_BITS(3), .ZERO_REG(1'b1)) dut2 (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus2)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        ie;
    logic [4:0]  ir;
    logic        fl;
    logic [31:0] eda;
    logic [31:0] edb;
    logic        eba;
    logic        ebb;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t v(logic we, logic [4:0] wr, logic [31:0] wd, logic [4:0] ra,
                             logic [4:0] rb, logic ie, logic [4:0] ir, logic fl,
                             logic [31:0] eda, logic [31:0] edb, logic eba, logic ebb,
                             logic [5:0] ecnt);
    vec_t r;
    r.we = we; r.wr = wr; r.wd = wd; r.ra = ra; r.rb = rb; r.ie = ie; r.ir = ir; r.fl = fl;
    r.eda = eda; r.edb = edb; r.eba = eba; r.ebb = ebb; r.ecnt = ecnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_writeReg    = '0;
    bus.data_writeReg    = '0;
    bus.ctrl_issueEnable = 1'b0;
    bus.ctrl_issueReg    = '0;
    bus.ctrl_flush       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.ctrl_readRegA     = '0;
    bus.ctrl_readRegB     = '0;
    bus2.ctrl_writeEnable = 1'b0;
    bus2.ctrl_writeReg    = '0;
    bus2.data_writeReg    = '0;
    bus2.ctrl_readRegA    = '0;
    bus2.ctrl_readRegB    = '0;
    bus2.ctrl_issueEnable = 1'b0;
    bus2.ctrl_issueReg    = '0;
    bus2.ctrl_flush       = 1'b0;

    vecs[0]  = v(0, 0, 32'h0,        0, 5, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0);
    vecs[1]  = v(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0,        0, 0, 0);
    vecs[2]  = v(1, 0, 32'h1234,     0, 5, 0, 0, 0, 32'h0,        32'hDEADBEEF, 0, 0, 0);
    vecs[3]  = v(0, 0, 32'h0,        0, 5, 0, 0, 0, 32'h0,        32'hDEADBEEF, 0, 0, 0);
    vecs[4]  = v(0, 0, 32'h0,        7, 5, 1, 7, 0, 32'h0,        32'hDEADBEEF, 0, 0, 0);
    vecs[5]  = v(0, 0, 32'h0,        7, 7, 0, 0, 0, 32'h0,        32'h0,        1, 1, 1);
    vecs[6]  = v(1, 7, 32'h55,       7, 5, 0, 0, 0, 32'h55,       32'hDEADBEEF, 0, 0, 1);
    vecs[7]  = v(0, 0, 32'h0,        7, 5, 0, 0, 0, 32'h55,       32'hDEADBEEF, 0, 0, 0);
    vecs[8]  = v(0, 0, 32'h0,        3, 0, 1, 3, 0, 32'h0,        32'h0,        0, 0, 0);
    vecs[9]  = v(1, 3, 32'hAAAA,     3, 3, 1, 3, 0, 32'hAAAA,     32'hAAAA,     0, 0, 1);
    vecs[10] = v(0, 0, 32'h0,        3, 4, 0, 0, 0, 32'hAAAA,     32'h0,        1, 0, 1);
    vecs[11] = v(1, 3, 32'hBBBB,     3, 4, 1, 4, 0, 32'hBBBB,     32'h0,        0, 0, 1);
    vecs[12] = v(0, 0, 32'h0,        3, 4, 0, 0, 0, 32'hBBBB,     32'h0,        0, 1, 1);
    vecs[13] = v(0, 0, 32'h0,        0, 4, 1, 0, 0, 32'h0,        32'h0,        0, 1, 1);
    vecs[14] = v(0, 0, 32'h0,        0, 4, 0, 0, 0, 32'h0,        32'h0,        0, 1, 1);
    vecs[15] = v(1, 5, 32'hCAFE,     5, 4, 0, 0, 0, 32'hCAFE,     32'h0,        0, 1, 1);
    vecs[16] = v(0, 0, 32'h0,        5, 4, 0, 0, 0, 32'hCAFE,     32'h0,        0, 1, 1);

    // Power-up reset, then every address must read zero and idle.
    repeat (2) @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      bus.ctrl_readRegA = 5'(a);
      bus.ctrl_readRegB = 5'(31 - a);
      #1;
      check("reset_data_a", bus.data_readRegA, 32'h0);
      check("reset_data_b", bus.data_readRegB, 32'h0);
      check("reset_busy_a", 32'(bus.busy_A), 32'h0);
    end
    check("reset_count", 32'(bus.pending_count), 32'h0);
    tick();

    for (int i = 0; i < 17; i++) begin
      bus.ctrl_writeEnable = vecs[i].we;
      bus.ctrl_writeReg    = vecs[i].wr;
      bus.data_writeReg    = vecs[i].wd;
      bus.ctrl_readRegA    = vecs[i].ra;
      bus.ctrl_readRegB    = vecs[i].rb;
      bus.ctrl_issueEnable = vecs[i].ie;
      bus.ctrl_issueReg    = vecs[i].ir;
      bus.ctrl_flush       = vecs[i].fl;
      #1;
      check($sformatf("vec%0d_da", i), bus.data_readRegA, vecs[i].eda);
      check($sformatf("vec%0d_db", i), bus.data_readRegB, vecs[i].edb);
      check($sformatf("vec%0d_ba", i), 32'(bus.busy_A), 32'(vecs[i].eba));
      check($sformatf("vec%0d_bb", i), 32'(bus.busy_B), 32'(vecs[i].ebb));
      check($sformatf("vec%0d_cnt", i), 32'(bus.pending_count), 32'(vecs[i].ecnt));
      tick();
    end
    idle();

    // Fill the scoreboard; r4 is already pending so the total lands exactly on 31.
    for (int r = 1; r < 32; r++) begin
      bus.ctrl_issueEnable = 1'b1;
      bus.ctrl_issueReg    = 5'(r);
      tick();
    end
    idle();
    #1;
    check("fill_count", 32'(bus.pending_count), 32'd31);
    bus.ctrl_issueEnable = 1'b1;
    bus.ctrl_issueReg    = 5'd9;
    tick();
    idle();
    #1;
    check("reissue_count", 32'(bus.pending_count), 32'd31);

    bus.ctrl_flush       = 1'b1;
    bus.ctrl_issueEnable = 1'b1;
    bus.ctrl_issueReg    = 5'd2;
    tick();
    idle();
    #1;
    check("flush_count", 32'(bus.pending_count), 32'd1);
    for (int a = 0; a < 32; a++) begin
      bus.ctrl_readRegA = 5'(a);
      #1;
      check($sformatf("flush_busy_r%0d", a), 32'(bus.busy_A), (a == 2) ? 32'd1 : 32'd0);
    end
    bus.ctrl_readRegA = 5'd5;
    bus.ctrl_readRegB = 5'd2;
    #1;
    check("flush_keeps_data", bus.data_readRegA, 32'hCAFE);

    // Mid-run reset must clear outputs without any clock edge.
    @(negedge clock);
    ctrl_reset = 1'b1;
    #1;
    check("midreset_data", bus.data_readRegA, 32'h0);
    check("midreset_busy", 32'(bus.busy_B), 32'h0);
    check("midreset_count", 32'(bus.pending_count), 32'h0);
    bus.ctrl_flush       = 1'b1;
    bus.ctrl_issueEnable = 1'b1;
    bus.ctrl_issueReg    = 5'd6;
    tick();
    idle();
    ctrl_reset = 1'b0;
    #1;
    check("post_reset_count", 32'(bus.pending_count), 32'h0);
    for (int a = 0; a < 32; a++) begin
      bus.ctrl_readRegA = 5'(a);
      #1;
      check($sformatf("post_reset_r%0d", a), bus.data_readRegA, 32'h0);
    end

    // Narrow 16-bit x 8 configuration.
    bus2.ctrl_writeEnable = 1'b1;
    bus2.ctrl_writeReg    = 3'd7;
    bus2.data_writeReg    = 16'hFFFF;
    tick();
    bus2.ctrl_writeEnable = 1'b0;
    bus2.ctrl_readRegA    = 3'd7;
    #1;
    check("narrow_read_r7", 32'(bus2.data_readRegA), 32'h0000FFFF);
    for (int r = 1; r < 8; r++) begin
      bus2.ctrl_issueEnable = 1'b1;
      bus2.ctrl_issueReg    = 3'(r);
      tick();
    end
    bus2.ctrl_issueEnable = 1'b0;
    #1;
    check("narrow_count", 32'(bus2.pending_count), 32'd7);
    check("narrow_busy_r7", 32'(bus2.busy_A), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
